// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU operation codes, control bundle.
package riscv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
      logic    branch;
      logic    jump;
   } ctrl_t;

   // ALU op for OP / OP-IMM; alt is funct7[5] where it is meaningful
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: control bundle, immediate, illegal flag.
module decode_ctrl
   import riscv_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic [31:0] instr_i,
   output ctrl_t       ctrl_o,
   output logic [31:0] imm_o,
   output logic        illegal_o
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad;
   logic        use_rd, use_rs1, use_rs2;
   ctrl_t       ctrl;
   logic [31:0] imm;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];

   assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {instr_i[31:12], 12'b0};
   assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   // Per-opcode control; register-range check only covers fields the format really uses
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      imm         = '0;
      bad         = 1'b0;
      use_rd      = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      case (opcode)
         OP_LUI: begin
            imm = imm_u; ctrl.alu_op = ALU_PASS_B; ctrl.alu_src = 1'b1;
            ctrl.reg_write = 1'b1; use_rd = 1'b1;
         end
         OP_AUIPC: begin
            imm = imm_u; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; use_rd = 1'b1;
         end
         OP_JAL: begin
            imm = imm_j; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
            use_rd = 1'b1;
         end
         OP_JALR: begin
            imm = imm_i; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
            use_rd = 1'b1; use_rs1 = 1'b1;
         end
         OP_BRANCH: begin
            imm = imm_b; ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_LOAD: begin
            imm = imm_i; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
            ctrl.mem_to_reg = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
         end
         OP_STORE: begin
            imm = imm_s; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_IMM: begin
            imm = imm_i; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
            ctrl.alu_op = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
            use_rd = 1'b1; use_rs1 = 1'b1;
            if (f3 == 3'b001 && f7 != 7'h00) bad = 1'b1;
            if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
         end
         OP_REG: begin
            ctrl.reg_write = 1'b1; ctrl.alu_op = alu_from_funct3(f3, f7[5]);
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
            if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (use_rd  && int'(instr_i[11:7])  >= NREGS) bad = 1'b1;
      if (use_rs1 && int'(instr_i[19:15]) >= NREGS) bad = 1'b1;
      if (use_rs2 && int'(instr_i[24:20]) >= NREGS) bad = 1'b1;
   end

   // Illegal instructions carry no side effects downstream
   always_comb begin
      ctrl_o    = ctrl;
      imm_o     = imm;
      illegal_o = bad;
      if (bad) begin
         ctrl_o        = '0;
         ctrl_o.alu_op = ALU_ADD;
         imm_o         = '0;
      end
   end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage: register file, decoder, output register + skid buffer with WB snooping.
module decode_stage_hs
   import riscv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int RF_RESET  = 1,
   parameter int BYPASS_EN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [3:0]      out_alu_op,
   output logic            out_alu_src,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_reg_write,
   output logic            out_mem_to_reg,
   output logic            out_branch,
   output logic            out_jump,
   output logic [2:0]      out_funct3,
   output logic            out_illegal,
   output logic [31:0]     decode_count,
   output logic [31:0]     stall_count
);

   localparam int AW = $clog2(NREGS);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      ctrl_t           ctrl;
      logic            illegal;
   } entry_t;

   logic [XLEN-1:0] regs_q [1:NREGS-1];
   entry_t          out_q, out_d, skid_q, skid_d, in_entry;
   logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic [31:0]     dec_cnt_q, stall_cnt_q;
   logic            wb_commit, snoop_hit, accept, load_out;
   ctrl_t           dec_ctrl;
   logic [31:0]     dec_imm;
   logic            dec_illegal;

   xlen_legal:  assert property (@(posedge clk) XLEN == 32);
   nregs_legal: assert property (@(posedge clk) NREGS == 32 || NREGS == 16);

   assign wb_commit = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREGS);
   assign snoop_hit = (BYPASS_EN != 0) && wb_commit;
   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && in_ready && !flush;
   assign load_out  = !out_valid_q || out_ready;

   decode_ctrl #(.NREGS(NREGS)) u_dec (
      .instr_i   (in_instr),
      .ctrl_o    (dec_ctrl),
      .imm_o     (dec_imm),
      .illegal_o (dec_illegal)
   );

   // x0 is hard-wired; out-of-range indices read as zero
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      logic [XLEN-1:0] val;
      val = '0;
      if (idx != 5'd0 && int'(idx) < NREGS) begin
         if (snoop_hit && wb_rd == idx) val = wb_data;
         else                           val = regs_q[idx[AW-1:0]];
      end
      return val;
   endfunction

   // A held entry picks up any register written this cycle
   function automatic entry_t snoop(input entry_t e);
      entry_t r;
      r = e;
      if (snoop_hit && e.rs1 == wb_rd) r.rs1_data = wb_data;
      if (snoop_hit && e.rs2 == wb_rd) r.rs2_data = wb_data;
      return r;
   endfunction

   // One register per generate slot; writes to x0 or beyond NREGS match nothing
   for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
      if (RF_RESET != 0) begin : g_rst
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                              regs_q[gi] <= '0;
            else if (wb_en && wb_rd == 5'(gi))       regs_q[gi] <= wb_data;
         end
      end else begin : g_norst
         always_ff @(posedge clk) begin
            if (wb_en && wb_rd == 5'(gi)) regs_q[gi] <= wb_data;
         end
      end
   end

   // Assemble the decoded entry for the instruction on the input
   always_comb begin
      in_entry          = '0;
      in_entry.pc       = in_pc;
      in_entry.rs1_data = rf_read(in_instr[19:15]);
      in_entry.rs2_data = rf_read(in_instr[24:20]);
      in_entry.imm      = dec_imm;
      in_entry.rd       = in_instr[11:7];
      in_entry.rs1      = in_instr[19:15];
      in_entry.rs2      = in_instr[24:20];
      in_entry.funct3   = in_instr[14:12];
      in_entry.ctrl     = dec_ctrl;
      in_entry.illegal  = dec_illegal;
   end

   // Output/skid next state: skid drains first, so order is preserved
   always_comb begin
      out_d        = snoop(out_q);
      skid_d       = snoop(skid_q);
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (load_out) begin
         if (skid_valid_q) begin
            out_d        = snoop(skid_q);
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = snoop(in_entry);
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = snoop(in_entry);
         skid_valid_d = 1'b1;
      end
   end

   // Buffer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // Accept and stall counters, free-running with natural wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept)                    dec_cnt_q   <= dec_cnt_q + 32'd1;
         if (out_valid_q && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_pc         = out_q.pc;
   assign out_rs1_data   = out_q.rs1_data;
   assign out_rs2_data   = out_q.rs2_data;
   assign out_imm        = out_q.imm;
   assign out_rd         = out_q.rd;
   assign out_rs1        = out_q.rs1;
   assign out_rs2        = out_q.rs2;
   assign out_alu_op     = out_q.ctrl.alu_op;
   assign out_alu_src    = out_q.ctrl.alu_src;
   assign out_mem_read   = out_q.ctrl.mem_read;
   assign out_mem_write  = out_q.ctrl.mem_write;
   assign out_reg_write  = out_q.ctrl.reg_write;
   assign out_mem_to_reg = out_q.ctrl.mem_to_reg;
   assign out_branch     = out_q.ctrl.branch;
   assign out_jump       = out_q.ctrl.jump;
   assign out_funct3     = out_q.funct3;
   assign out_illegal    = out_q.illegal;
   assign decode_count   = dec_cnt_q;
   assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: RV32I instance (a_*) and RV32E instance (b_*).
module tb_decode_stage_hs;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, wb_en, out_ready;
   logic [31:0] in_pc, in_instr, wb_data;
   logic [4:0]  wb_rd;

   logic        a_in_ready, a_out_valid, a_alu_src, a_mr, a_mw, a_rw, a_m2r, a_br, a_j, a_ill;
   logic [31:0] a_pc, a_rs1d, a_rs2d, a_imm, a_dec, a_stall;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [3:0]  a_alu_op;
   logic [2:0]  a_f3;

   logic        b_in_ready, b_out_valid, b_alu_src, b_mr, b_mw, b_rw, b_m2r, b_br, b_j, b_ill;
   logic [31:0] b_pc, b_rs1d, b_rs2d, b_imm, b_dec, b_stall;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [3:0]  b_alu_op;
   logic [2:0]  b_f3;

   int checks   = 0;
   int failures = 0;
   int exp_dec  = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   decode_stage_hs dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_rs1_data(a_rs1d),
      .out_rs2_data(a_rs2d), .out_imm(a_imm), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
      .out_alu_op(a_alu_op), .out_alu_src(a_alu_src), .out_mem_read(a_mr), .out_mem_write(a_mw),
      .out_reg_write(a_rw), .out_mem_to_reg(a_m2r), .out_branch(a_br), .out_jump(a_j),
      .out_funct3(a_f3), .out_illegal(a_ill), .decode_count(a_dec), .stall_count(a_stall)
   );

   decode_stage_hs #(.NREGS(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_rs1_data(b_rs1d),
      .out_rs2_data(b_rs2d), .out_imm(b_imm), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
      .out_alu_op(b_alu_op), .out_alu_src(b_alu_src), .out_mem_read(b_mr), .out_mem_write(b_mw),
      .out_reg_write(b_rw), .out_mem_to_reg(b_m2r), .out_branch(b_br), .out_jump(b_j),
      .out_funct3(b_f3), .out_illegal(b_ill), .decode_count(b_dec), .stall_count(b_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_rd   = rd;
      wb_data = data;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_instr = '0; wb_rd = '0; wb_data = '0;
      step(); step();
      chk("rst_out_valid", a_out_valid, 1'b0);
      chk("rst_in_ready", a_in_ready, 1'b1);
      chk("rst_dec_cnt", a_dec, 0);
      chk("rst_stall_cnt", a_stall, 0);
      chk("rst_out_pc", a_pc, 0);
      $display("reset: out_valid=%0d in_ready=%0d", a_out_valid, a_in_ready);
      rst_n = 1'b1;

      // x5 = 0x1234, then ADDI x6,x5,-1
      out_ready = 1'b1;
      wb(5'd5, 32'h1234); step(); wb_en = 1'b0;
      offer(32'h100, 32'hFFF28313); step(); exp_dec++;
      $display("addi: pc=%h rs1=%h imm=%h", a_pc, a_rs1d, a_imm);
      chk("addi_valid", a_out_valid, 1'b1);
      chk("addi_pc", a_pc, 32'h100);
      chk("addi_rs1d", a_rs1d, 32'h1234);
      chk("addi_imm", a_imm, 32'hFFFF_FFFF);
      chk("addi_aluop", a_alu_op, 4'd0);
      chk("addi_alusrc", a_alu_src, 1'b1);
      chk("addi_rw", a_rw, 1'b1);
      chk("addi_rd", a_rd, 5'd6);
      chk("addi_dec", a_dec, exp_dec);

      // back-to-back decode patterns
      offer(32'h104, 32'h403100B3); step(); exp_dec++;          // SUB x1,x2,x3
      $display("sub: pc=%h aluop=%0d", a_pc, a_alu_op);
      chk("sub_pc", a_pc, 32'h104);
      chk("sub_aluop", a_alu_op, 4'd1);
      chk("sub_alusrc", a_alu_src, 1'b0);
      offer(32'h108, 32'hFE208CE3); step(); exp_dec++;          // BEQ x1,x2,-8
      $display("beq: pc=%h imm=%h", a_pc, a_imm);
      chk("beq_imm", a_imm, 32'hFFFF_FFF8);
      chk("beq_branch", a_br, 1'b1);
      chk("beq_aluop", a_alu_op, 4'd1);
      chk("beq_rw", a_rw, 1'b0);
      offer(32'h10C, 32'h123452B7); step(); exp_dec++;          // LUI x5,0x12345
      $display("lui: pc=%h imm=%h", a_pc, a_imm);
      chk("lui_imm", a_imm, 32'h1234_5000);
      chk("lui_aluop", a_alu_op, 4'd10);
      offer(32'h110, 32'h0000007F); step(); exp_dec++;          // unknown opcode
      $display("op7f: illegal=%0d", a_ill);
      chk("op7f_illegal", a_ill, 1'b1);
      chk("op7f_valid", a_out_valid, 1'b1);
      chk("op7f_imm", a_imm, 32'h0);
      chk("op7f_rw", a_rw, 1'b0);
      offer(32'h114, 32'h02208033); step(); exp_dec++;          // OP funct7=0x01
      $display("f7_01: illegal=%0d", a_ill);
      chk("f701_illegal", a_ill, 1'b1);
      chk("f701_aluop", a_alu_op, 4'd0);
      in_valid = 1'b0; step();
      chk("idle_valid", a_out_valid, 1'b0);

      // backpressure: three offered, two buffered, third waits
      out_ready = 1'b0;
      offer(32'h200, 32'hFFF28313); step(); exp_dec++;
      chk("st0_pc", a_pc, 32'h200);
      chk("st0_in_ready", a_in_ready, 1'b1);
      offer(32'h204, 32'hFFF28313); step(); exp_dec++; exp_stall++;
      chk("st1_in_ready", a_in_ready, 1'b0);
      chk("st1_pc", a_pc, 32'h200);
      offer(32'h208, 32'hFFF28313); step(); exp_stall++;
      chk("st2_in_ready", a_in_ready, 1'b0);
      chk("st2_dec", a_dec, exp_dec);
      out_ready = 1'b1; step();
      $display("drain: pc=%h in_ready=%0d", a_pc, a_in_ready);
      chk("st3_pc", a_pc, 32'h204);
      chk("st3_in_ready", a_in_ready, 1'b1);
      step(); exp_dec++;
      chk("st4_pc", a_pc, 32'h208);
      chk("st4_dec", a_dec, exp_dec);
      in_valid = 1'b0; step();
      chk("st5_stall", a_stall, exp_stall);
      chk("st5_valid", a_out_valid, 1'b0);

      // snoop: x7 written while ADDI x8,x7,0 sits in the skid entry
      out_ready = 1'b0;
      offer(32'h300, 32'h00100093); step(); exp_dec++;
      offer(32'h304, 32'h00038413); step(); exp_dec++; exp_stall++;
      chk("sn_in_ready", a_in_ready, 1'b0);
      in_valid = 1'b0; wb(5'd7, 32'hCAFE); step(); exp_stall++; wb_en = 1'b0;
      out_ready = 1'b1; step();
      $display("snoop: pc=%h rs1=%h", a_pc, a_rs1d);
      chk("sn_pc", a_pc, 32'h304);
      chk("sn_rs1d", a_rs1d, 32'hCAFE);
      step();
      // write in the same cycle as accept
      wb(5'd10, 32'hBEEF); offer(32'h308, 32'h00050593); step(); exp_dec++; wb_en = 1'b0;
      $display("bypass: pc=%h rs1=%h", a_pc, a_rs1d);
      chk("byp_rs1d", a_rs1d, 32'hBEEF);
      offer(32'h30C, 32'h00750633); step(); exp_dec++;          // ADD x12,x10,x7
      chk("add_rs1d", a_rs1d, 32'hBEEF);
      chk("add_rs2d", a_rs2d, 32'hCAFE);
      in_valid = 1'b0; step();

      // flush with both entries full and another offered; WB in flush cycle
      out_ready = 1'b0;
      offer(32'h400, 32'hFFF28313); step(); exp_dec++;
      offer(32'h404, 32'hFFF28313); step(); exp_dec++; exp_stall++;
      offer(32'h408, 32'hFFF28313);
      chk("fl_full", a_in_ready, 1'b0);
      flush = 1'b1; wb(5'd13, 32'h55); step(); exp_stall++;
      flush = 1'b0; wb_en = 1'b0;
      $display("flush: out_valid=%0d in_ready=%0d dec=%0d", a_out_valid, a_in_ready, a_dec);
      chk("fl_valid", a_out_valid, 1'b0);
      chk("fl_in_ready", a_in_ready, 1'b1);
      chk("fl_dec", a_dec, exp_dec);
      offer(32'h40C, 32'hFFF28313); flush = 1'b1; step(); flush = 1'b0;
      chk("fl2_valid", a_out_valid, 1'b0);
      chk("fl2_dec", a_dec, exp_dec);
      out_ready = 1'b1;
      offer(32'h410, 32'h00068713); step(); exp_dec++;          // ADDI x14,x13,0
      chk("fl_wb_rs1d", a_rs1d, 32'h55);
      in_valid = 1'b0; step();
      chk("fl_stall", a_stall, exp_stall);

      // RV32E instance: high register indices
      offer(32'h500, 32'h002088B3); step(); exp_dec++;          // ADD x17,x1,x2
      $display("rv32e: a_ill=%0d b_ill=%0d", a_ill, b_ill);
      chk("e_a_ill", a_ill, 1'b0);
      chk("e_a_rw", a_rw, 1'b1);
      chk("e_b_ill", b_ill, 1'b1);
      chk("e_b_rw", b_rw, 1'b0);
      chk("e_b_valid", b_out_valid, 1'b1);
      in_valid = 1'b0; wb(5'd20, 32'h777); step(); wb_en = 1'b0;
      offer(32'h504, 32'h000A0093); step(); exp_dec++;          // ADDI x1,x20,0
      chk("e_a_x20", a_rs1d, 32'h777);
      chk("e_b_x20", b_rs1d, 32'h0);
      offer(32'h508, 32'h002081B3); step(); exp_dec++;          // ADD x3,x1,x2
      chk("e_b_legal", b_ill, 1'b0);
      chk("e_b_rw3", b_rw, 1'b1);
      in_valid = 1'b0; step();

      // asynchronous reset with both entries full
      out_ready = 1'b0;
      offer(32'h600, 32'hFFF28313); step();
      offer(32'h604, 32'hFFF28313); step();
      chk("ar_full", a_in_ready, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      $display("async reset: out_valid=%0d dec=%0d", a_out_valid, a_dec);
      chk("ar_valid", a_out_valid, 1'b0);
      chk("ar_in_ready", a_in_ready, 1'b1);
      chk("ar_dec", a_dec, 0);
      chk("ar_stall", a_stall, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      offer(32'h700, 32'h00028093); step();                     // ADDI x1,x5,0
      chk("ar_x5", a_rs1d, 32'h0);
      chk("ar_dec1", a_dec, 1);
      in_valid = 1'b0; step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
